// File: rtl/omni_act_injector.sv
// Edge-of-array activation injector: accepts ROWS-wide beats, applies systolic row skew
// and steers each lane onto the left- or right-facing bus. Optional stats: OMNI_INJ_STATS_EN.

module omni_inj_lane #(
    parameter int A_W   = 16,
    parameter int DEPTH = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_vld,
    input  logic [A_W-1:0] ld_dat,
    output logic           vld,
    output logic [A_W-1:0] dat
);
    logic [DEPTH-1:0]          v;
    logic [DEPTH-1:0][A_W-1:0] d;

    // Shifts unconditionally; idle cycles carry zeroed bubbles so lane skew never drifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            d <= '0;
        end else begin
            v[0] <= ld_vld;
            d[0] <= ld_dat;
            for (int k = 1; k < DEPTH; k++) begin
                v[k] <= v[k-1];
                d[k] <= d[k-1];
            end
        end
    end

    assign vld = v[DEPTH-1];
    assign dat = d[DEPTH-1];
endmodule

module omni_act_injector #(
    parameter int A_W   = 16,
    parameter int ROWS  = 4,
    parameter int LEN_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                dir,
    input  logic [LEN_W-1:0]    len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ROWS*A_W-1:0] in_act,
    output logic [ROWS*A_W-1:0] out_act_lft,
    output logic [ROWS*A_W-1:0] out_act_rht,
    output logic [ROWS-1:0]     out_valid,
    output logic                busy,
    output logic                done
`ifdef OMNI_INJ_STATS_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);
    localparam int DR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                    state;
    logic                      dir_q;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          beat_cnt;
    logic [DR_W-1:0]           drain_cnt;
    logic                      busy_q;
    logic                      done_q;
    logic                      accept;
    logic [ROWS-1:0]           lane_vld;
    logic [ROWS-1:0][A_W-1:0]  lane_dat;

    assign in_ready = (state == STREAM);
    assign accept   = in_ready & in_valid;
    assign busy     = busy_q;
    assign done     = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            len_q     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (len != '0) begin
                            dir_q    <= dir;
                            len_q    <= len;
                            beat_cnt <= '0;
                            state    <= STREAM;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (beat_cnt == len_q - LEN_W'(1)) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // ROWS cycles lets the deepest lane empty before done.
                    if (drain_cnt == DR_W'(ROWS - 1)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DR_W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        omni_inj_lane #(.A_W(A_W), .DEPTH(r + 1)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .ld_vld (accept),
            .ld_dat (accept ? in_act[r*A_W +: A_W] : '0),
            .vld    (lane_vld[r]),
            .dat    (lane_dat[r])
        );
        assign out_valid[r]             = lane_vld[r];
        assign out_act_lft[r*A_W +: A_W] = (lane_vld[r] && !dir_q) ? lane_dat[r] : '0;
        assign out_act_rht[r*A_W +: A_W] = (lane_vld[r] &&  dir_q) ? lane_dat[r] : '0;
    end

`ifdef OMNI_INJ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == IDLE && start)
            stall_cnt <= '0;
        else if (state == STREAM && !in_valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_omni_act_injector.sv
// Directed bench for omni_act_injector; a cycle-history model predicts every output each cycle.
`timescale 1ns/1ps
module tb_omni_act_injector;
    localparam int A_W = 16, ROWS = 4, LEN_W = 8, W = ROWS*A_W;

    logic clk = 0, rst = 1, start = 0, dir = 0, in_valid = 0;
    logic [LEN_W-1:0] len = '0;
    logic [W-1:0] in_act = '0;
    logic in_ready, busy, done;
    logic [W-1:0] out_act_lft, out_act_rht;
    logic [ROWS-1:0] out_valid;
`ifdef OMNI_INJ_STATS_EN
    logic [15:0] stall_cnt;
`endif

    omni_act_injector #(.A_W(A_W), .ROWS(ROWS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
        .out_act_lft(out_act_lft), .out_act_rht(out_act_rht),
        .out_valid(out_valid), .busy(busy), .done(done)
`ifdef OMNI_INJ_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, errs = 0, done_seen = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Model: which cycles accepted a beat, when done is due, which bus is latched.
    int cyc = 0, rst_at = -1, m_done_at = -1, m_rem = 0;
    bit chk_en = 0, m_stream = 0, m_dir = 0;
    int m_stall = 0;
    bit hist_v [0:1023];
    logic [W-1:0] hist_d [0:1023];

    always @(posedge clk) begin
        bit idle, acc;
        idle = !m_stream && !(cyc <= m_done_at);
        acc  = m_stream && in_valid;
        hist_v[cyc] = 0;
        hist_d[cyc] = in_act;
        if (rst) begin
            chk_en = 1; rst_at = cyc; m_done_at = -1; m_stream = 0;
            m_dir = 0; m_rem = 0; m_stall = 0;
        end else begin
            hist_v[cyc] = acc;
            if (m_stream && !in_valid && m_stall < 16'hFFFF) m_stall++;
            if (idle && start) begin
                m_stall = 0;
                if (len != 0) begin m_stream = 1; m_rem = len; m_dir = dir; end
                else m_done_at = cyc + 1;
            end
            if (acc) begin
                m_rem--;
                if (m_rem == 0) begin m_stream = 0; m_done_at = cyc + ROWS + 1; end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [W-1:0] el, er;
            logic [ROWS-1:0] ev;
            el = '0; er = '0; ev = '0;
            for (int r = 0; r < ROWS; r++) begin
                int src;
                src = cyc - 1 - r;
                if (src >= 0 && src > rst_at && hist_v[src]) begin
                    ev[r] = 1;
                    if (m_dir) er[r*A_W +: A_W] = hist_d[src][r*A_W +: A_W];
                    else       el[r*A_W +: A_W] = hist_d[src][r*A_W +: A_W];
                end
            end
            chk("in_ready", in_ready, m_stream);
            chk("busy", busy, m_stream || (cyc <= m_done_at));
            chk("done", done, cyc == m_done_at);
            chk("out_valid", out_valid, ev);
            chk("out_act_lft", out_act_lft, el);
            chk("out_act_rht", out_act_rht, er);
`ifdef OMNI_INJ_STATS_EN
            chk("stall_cnt", stall_cnt, m_stall);
`endif
            if (done === 1'b1) done_seen++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int d0;
        step(2);
        rst = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);

        // Reset mid-stream after three accepted beats.
        start = 1; dir = 0; len = 8; step;
        start = 0; in_valid = 1; in_act = 64'h1113_1112_1111_1110; step;
        in_act = 64'h2223_2222_2221_2220; step;
        in_act = 64'h3333_3332_3331_3330; step;
        in_valid = 0; rst = 1; step;
        rst = 0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_lft", out_act_lft, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 0);
        d0 = done_seen; step(6);
        chk("midrst_no_done", done_seen - d0, 0);

        // Basic skew.
        start = 1; dir = 0; len = 1; step;
        start = 0; in_valid = 1; in_act = 64'h0004_0003_0002_0001;
        chk("skew_ready", in_ready, 1);
        step; in_valid = 0;
        chk("skew_l0", out_act_lft, 64'h0000_0000_0000_0001); chk("skew_v0", out_valid, 4'b0001);
        step; chk("skew_l1", out_act_lft, 64'h0000_0000_0002_0000); chk("skew_v1", out_valid, 4'b0010);
        step; chk("skew_l2", out_act_lft, 64'h0000_0003_0000_0000); chk("skew_v2", out_valid, 4'b0100);
        step; chk("skew_l3", out_act_lft, 64'h0004_0000_0000_0000); chk("skew_v3", out_valid, 4'b1000);
        chk("skew_rht", out_act_rht, 0); chk("skew_nodone", done, 0);
        step; chk("skew_done", done, 1); chk("skew_done_v", out_valid, 0);
        step; chk("skew_done_off", done, 0); chk("skew_idle", busy, 0);

        // Direction 1 with a bubble: A, -, B, C.
        start = 1; dir = 1; len = 3; step;
        start = 0; in_valid = 1; in_act = 64'h0A03_0A02_0A01_0A00; step;
        in_valid = 0;
        chk("dir_a", out_act_rht[15:0], 16'h0A00); chk("dir_a_v", out_valid[0], 1);
        step; in_valid = 1; in_act = 64'h0B03_0B02_0B01_0B00;
        chk("dir_bub", out_act_rht[15:0], 16'h0000); chk("dir_bub_v", out_valid[0], 0);
        step; in_act = 64'h0C03_0C02_0C01_0C00;
        chk("dir_b", out_act_rht[15:0], 16'h0B00);
        step; in_valid = 0;
        chk("dir_c", out_act_rht[15:0], 16'h0C00);
        chk("dir_ready_drop", in_ready, 0);
        chk("dir_lft", out_act_lft, 0);
`ifdef OMNI_INJ_STATS_EN
        chk("dir_stall", stall_cnt, 1);
`endif
        step(5);

        // Zero length.
        start = 1; dir = 0; len = 0; step;
        start = 0;
        chk("zl_done", done, 1); chk("zl_ready", in_ready, 0); chk("zl_valid", out_valid, 0);
        step; chk("zl_done_off", done, 0); chk("zl_idle", busy, 0);

        // Inputs ignored during DRAIN.
        start = 1; dir = 1; len = 2; step;
        start = 0; in_valid = 1; in_act = 64'h0D03_0D02_0D01_0D00; step;
        in_act = 64'h0E03_0E02_0E01_0E00; step;
        start = 1; dir = 0; in_valid = 1; in_act = 64'h0F03_0F02_0F01_0F00; step;
        chk("ign_ready", in_ready, 0);
        step; step;
        chk("ign_bus", out_act_rht[63:48], 16'h0E03); chk("ign_lft", out_act_lft, 0);
        start = 0; in_valid = 0; d0 = done_seen; step;
        chk("ign_done", done, 1);
        step; chk("ign_idle", busy, 0); chk("ign_one_done", done_seen - d0, 1);

        // Back-to-back tiles.
        d0 = done_seen;
        start = 1; dir = 0; len = 1; step;
        start = 0; in_valid = 1; in_act = 64'h1003_1002_1001_1000; step;
        in_valid = 0; step(4);
        chk("b2b_done1", done, 1);
        start = 1; dir = 1; len = 2; step;
        chk("b2b_idle", busy, 0);
        step;
        start = 0; in_valid = 1; in_act = 64'h2003_2002_2001_2000;
        chk("b2b_ready", in_ready, 1);
        step; in_act = 64'h3003_3002_3001_3000;
        chk("b2b_h0", out_act_rht[15:0], 16'h2000);
        step; in_valid = 0;
        chk("b2b_i0", out_act_rht[15:0], 16'h3000);
        chk("b2b_h1", out_act_rht[31:16], 16'h2001);
        step(6);
        chk("b2b_two_done", done_seen - d0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
